branch_recovery_ctrl: RTL

BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

---
 rtl/branch_recovery_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// branch_recovery_ctrl
//
// Sequences an external backup-PC FIFO for branch misprediction recovery.
// Each accepted predicted branch pushes its non-predicted path PC into the
// FIFO and its predicted direction into a local shadow queue that tracks the
// FIFO entry for entry. When execute resolves the oldest branch, the head is
// popped and compared. A mismatch causes a one-cycle RECOVER state. That
// state redirects fetch to the popped PC, flushes wrong-path work and clears
// the FIFO.
//
// Ports
//   clk            : clock, all state on posedge
//   clear          : synchronous active-high reset
//   br_issue       : fetch presents a predicted branch
//   pred_taken     : predicted direction of the issuing branch
//   br_resolve     : execute resolves the oldest outstanding branch
//   actual_taken   : true direction of the resolving branch
//   backup_pc      : FIFO output, holds the entry popped at the previous edge
//   fifo_enable    : FIFO write enable (follows fifo_push)
//   fifo_select    : FIFO input mux, 1 = target, 0 = fall-through
//   fifo_push      : FIFO push
//   fifo_pop       : FIFO pop
//   fifo_clear     : FIFO flush
//   stall          : fetch must hold and not issue a branch
//   redirect       : fetch must load redirect_pc
//   redirect_pc    : corrected PC, valid only while redirect=1
//   flush          : squash wrong-path instructions
//   mispredict_cnt : saturating count of mispredictions
//   underflow_err  : sticky, resolve seen with no outstanding branch
// -----------------------------------------------------------------------------
module branch_recovery_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        br_issue,
    input  logic        pred_taken,
    input  logic        br_resolve,
    input  logic        actual_taken,
    input  logic [10:0] backup_pc,
    output logic        fifo_enable,
    output logic        fifo_select,
    output logic        fifo_push,
    output logic        fifo_pop,
    output logic        fifo_clear,
    output logic        stall,
    output logic        redirect,
    output logic [10:0] redirect_pc,
    output logic        flush,
    output logic [7:0]  mispredict_cnt,
    output logic        underflow_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [DEPTH-1:0]  shadow_reg;      // bit 0 is the oldest branch
    logic [DEPTH-1:0]  shadow_next;
    logic [DEPTH-1:0]  shadow_shift;
    logic [CNT_W-1:0]  wr_slot;
    logic [7:0]        mcnt_reg;
    logic [7:0]        mcnt_next;
    logic              uflow_reg;
    logic              uflow_next;

    logic in_run;
    logic accept_issue;
    logic accept_resolve;
    logic mispredict;
    logic underflow_hit;

    // Clear masks every acceptance so no FIFO traffic escapes during reset.
    assign in_run         = ~clear & (state_reg == ST_RUN);
    assign accept_issue   = in_run & br_issue & (count_reg < CNT_FULL);
    assign accept_resolve = in_run & br_resolve & (count_reg != '0);
    assign mispredict     = accept_resolve & (actual_taken != shadow_reg[0]);
    assign underflow_hit  = in_run & br_resolve & (count_reg == '0);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. RECOVER always lasts exactly one cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:     if (mispredict) state_next = ST_RECOVER;
            ST_RECOVER: state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        fifo_enable = 1'b0;
        fifo_select = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_clear  = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        flush       = 1'b0;
        if (clear) begin
            fifo_clear = 1'b1;
        end else if (state_reg == ST_RECOVER) begin
            redirect    = 1'b1;
            redirect_pc = backup_pc;
            flush       = 1'b1;
            fifo_clear  = 1'b1;
            stall       = 1'b1;
        end else begin
            fifo_push   = accept_issue;
            fifo_enable = accept_issue;
            // The FIFO keeps the path not predicted.
            fifo_select = accept_issue & ~pred_taken;
            fifo_pop    = accept_resolve;
            // A full FIFO stalls even while an entry pops this cycle.
            stall       = (count_reg == CNT_FULL);
        end
    end

    // ---------------------------------------------------------------------
    // Occupancy count
    // ---------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        if (state_reg == ST_RECOVER) begin
            count_next = '0;
        end else if (accept_issue && !accept_resolve) begin
            count_next = count_reg + CNT_ONE;
        end else if (!accept_issue && accept_resolve) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // ---------------------------------------------------------------------
    // Shadow queue of predicted directions. It is a shift register with its
    // head at bit 0. A pop shifts down by one. A push lands just above the
    // surviving entries. With a simultaneous pop, that slot is count-1.
    // ---------------------------------------------------------------------
    assign shadow_shift = shadow_reg >> 1;
    assign wr_slot      = accept_resolve ? (count_reg - CNT_ONE) : count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shadow
            assign shadow_next[gi] =
                (state_reg == ST_RECOVER)                    ? 1'b0 :
                (accept_issue && (wr_slot == CNT_W'(gi)))    ? pred_taken :
                accept_resolve                               ? shadow_shift[gi] :
                                                               shadow_reg[gi];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Statistics and error flag
    // ---------------------------------------------------------------------
    always_comb begin
        mcnt_next = mcnt_reg;
        if ((state_reg == ST_RECOVER) && (mcnt_reg != 8'hFF)) begin
            mcnt_next = mcnt_reg + 8'd1;
        end
        uflow_next = uflow_reg | underflow_hit;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg  <= '0;
            shadow_reg <= '0;
            mcnt_reg   <= '0;
            uflow_reg  <= 1'b0;
        end else begin
            count_reg  <= count_next;
            shadow_reg <= shadow_next;
            mcnt_reg   <= mcnt_next;
            uflow_reg  <= uflow_next;
        end
    end

    assign mispredict_cnt = mcnt_reg;
    assign underflow_err  = uflow_reg;

endmodule
